// File: rtl/alu_cmd_driver.sv
// Command front end for alu_32bit: buffers ALU operations in a FIFO, drives the
// ALU operand/select registers, waits ALU_LAT cycles, and returns tagged results.
module alu_cmd_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [3:0]  cmd_sel_i,
  input  logic        cmd_cin_i,
  input  logic [31:0] cmd_a_i,
  input  logic [31:0] cmd_b_i,
  input  logic        cmd_chain_i,
  input  logic [3:0]  cmd_tag_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_cin_o,
  output logic [3:0]  alu_sel_o,
  input  logic [31:0] alu_f_i,
  input  logic        alu_cout_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_f_o,
  output logic        rsp_cout_o,
  output logic        rsp_zero_o,
  output logic        rsp_err_o,
  output logic [3:0]  rsp_tag_o,
  output logic        busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]  sel;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic        chain;
    logic [3:0]  tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  cmd_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          push, pop, issue, empty;
  cmd_t          head;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic          alu_cin_q, alu_cin_d;
  logic [3:0]    alu_sel_q, alu_sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_f_q, rsp_f_d;
  logic          rsp_cout_q, rsp_cout_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
  logic [3:0]    rsp_tag_q, rsp_tag_d;
  logic [31:0]   last_result_q, last_result_d;

  assign empty       = (count_q == '0);
  assign cmd_ready_o = (count_q != FULL_CNT);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign head        = mem_q[rd_ptr_q];
  assign busy_o      = (state_q != IDLE) || !empty;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{sel: cmd_sel_i, cin: cmd_cin_i, a: cmd_a_i,
                                   b: cmd_b_i, chain: cmd_chain_i, tag: cmd_tag_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_cin_d     = alu_cin_q;
    alu_sel_d     = alu_sel_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_f_d       = rsp_f_q;
    rsp_cout_d    = rsp_cout_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_err_d     = rsp_err_q;
    rsp_tag_d     = rsp_tag_q;
    last_result_d = last_result_q;
    issue         = 1'b0;
    pop           = 1'b0;

    case (state_q)
      IDLE: issue = !empty;
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d   = 1'b1;
          rsp_f_d       = alu_f_i;
          rsp_cout_d    = alu_cout_i;
          rsp_zero_d    = (alu_f_i == '0);
          rsp_err_d     = 1'b0;
          last_result_d = alu_f_i;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (empty) state_d = IDLE;
          else       issue   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // IDLE and a RESP handshake share the same issue path for back-to-back operation
    if (issue) begin
      pop = 1'b1;
      if (head.sel <= 4'd9) begin
        alu_a_d   = head.chain ? last_result_q : head.a;
        alu_b_d   = head.b;
        alu_sel_d = head.sel;
        alu_cin_d = (head.sel >= 4'd4) ? 1'b0 : head.cin;
        rsp_tag_d = head.tag;
        cnt_d     = CW'(ALU_LAT - 1);
        state_d   = WAIT;
      end else begin
        rsp_valid_d = 1'b1;
        rsp_f_d     = '0;
        rsp_cout_d  = 1'b0;
        rsp_zero_d  = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_tag_d   = head.tag;
        state_d     = RESP;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_cin_q     <= 1'b0;
      alu_sel_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_f_q       <= '0;
      rsp_cout_q    <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_tag_q     <= '0;
      last_result_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cin_q     <= alu_cin_d;
      alu_sel_q     <= alu_sel_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_f_q       <= rsp_f_d;
      rsp_cout_q    <= rsp_cout_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_err_q     <= rsp_err_d;
      rsp_tag_q     <= rsp_tag_d;
      last_result_q <= last_result_d;
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_cin_o   = alu_cin_q;
  assign alu_sel_o   = alu_sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_f_o     = rsp_f_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_zero_o  = rsp_zero_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tag_o   = rsp_tag_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural alu_32bit stand-in
// answering on the ALU side of the interface.
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_cin = 1'b0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_chain = 1'b0;
  logic [3:0]  cmd_tag = '0;
  logic [31:0] alu_a, alu_b, alu_f;
  logic        alu_cin, alu_cout;
  logic [3:0]  alu_sel;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_f;
  logic        rsp_cout, rsp_zero, rsp_err, busy;
  logic [3:0]  rsp_tag;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] A = 32'hA5A5F0F0;
  localparam logic [31:0] B = 32'h0F0F5A5A;

  always #5 clk = ~clk;

  alu_cmd_driver #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_sel_i(cmd_sel), .cmd_cin_i(cmd_cin), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .cmd_chain_i(cmd_chain), .cmd_tag_i(cmd_tag),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin), .alu_sel_o(alu_sel),
    .alu_f_i(alu_f), .alu_cout_i(alu_cout),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_f_o(rsp_f), .rsp_cout_o(rsp_cout), .rsp_zero_o(rsp_zero),
    .rsp_err_o(rsp_err), .rsp_tag_o(rsp_tag), .busy_o(busy)
  );

  // Reference ALU: 0 A+cin, 1 A+B+cin, 2 A-B (A+~B+cin), 3 A-1+cin, 4-9 logic/shift
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (alu_sel)
      4'd0: alu_sum = {1'b0, alu_a} + {32'd0, alu_cin};
      4'd1: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
      4'd2: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {32'd0, alu_cin};
      4'd3: alu_sum = {1'b0, alu_a} + 33'h0FFFFFFFF + {32'd0, alu_cin};
      4'd4: alu_sum = {1'b0, alu_a & alu_b};
      4'd5: alu_sum = {1'b0, alu_a | alu_b};
      4'd6: alu_sum = {1'b0, alu_a ^ alu_b};
      4'd7: alu_sum = {1'b0, ~alu_a};
      4'd8: alu_sum = {alu_a, 1'b0};
      4'd9: alu_sum = {1'b0, 1'b0, alu_a[31:1]};
      default: alu_sum = '0;
    endcase
  end
  assign alu_f    = alu_sum[31:0];
  assign alu_cout = alu_sum[32];

  task automatic set_cmd(input logic [3:0] sel, input logic cin, input logic [31:0] a,
                         input logic [31:0] b, input logic chain, input logic [3:0] tag);
    cmd_sel = sel; cmd_cin = cin; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_tag = tag;
  endtask

  task automatic push(input logic [3:0] sel, input logic cin, input logic [31:0] a,
                      input logic [31:0] b, input logic chain, input logic [3:0] tag);
    set_cmd(sel, cin, a, b, chain, tag);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({alu_a, alu_b, alu_cin, alu_sel, rsp_valid, rsp_f, rsp_cout, rsp_zero,
         rsp_err, rsp_tag, busy} !== '0)
      $display("FAIL reset_outputs: got a=%h b=%h sel=%h v=%b f=%h busy=%b, want all 0",
               alu_a, alu_b, alu_sel, rsp_valid, rsp_f, busy);
    else n_pass++;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    push(4'd1, 1'b0, A, B, 1'b0, 4'd3);
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL add_e0: got valid=%b busy=%b want 0/1", rsp_valid, busy);
    else n_pass++;
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || alu_a !== A || alu_b !== B || alu_sel !== 4'd1)
      $display("FAIL add_load: got valid=%b a=%h b=%h sel=%h want 0/%h/%h/1",
               rsp_valid, alu_a, alu_b, alu_sel, A, B);
    else n_pass++;
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_f !== 32'hB4B54B4A || rsp_cout !== 1'b0 ||
        rsp_tag !== 4'd3 || rsp_err !== 1'b0 || rsp_zero !== 1'b0)
      $display("FAIL add_rsp: got v=%b f=%h c=%b tag=%h err=%b z=%b want 1/B4B54B4A/0/3/0/0",
               rsp_valid, rsp_f, rsp_cout, rsp_tag, rsp_err, rsp_zero);
    else n_pass++;
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_f !== 32'hB4B54B4A)
      $display("FAIL add_hold: got v=%b f=%h want 1/B4B54B4A", rsp_valid, rsp_f);
    else n_pass++;
    ack();
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL add_ack: got v=%b busy=%b want 0/0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_sub_chain();
    push(4'd2, 1'b1, A, B, 1'b0, 4'd5);
    step(); step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_f !== 32'h96969696 || rsp_cout !== 1'b1 || rsp_tag !== 4'd5)
      $display("FAIL sub_rsp: got v=%b f=%h c=%b tag=%h want 1/96969696/1/5",
               rsp_valid, rsp_f, rsp_cout, rsp_tag);
    else n_pass++;
    ack();
    push(4'd4, 1'b0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b1, 4'd6);
    step(); step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_f !== 32'h06060606 || rsp_tag !== 4'd6)
      $display("FAIL chain_and: got v=%b f=%h tag=%h want 1/06060606/6", rsp_valid, rsp_f, rsp_tag);
    else n_pass++;
    ack();
  endtask

  task automatic test_cin_force_illegal();
    push(4'd6, 1'b1, A, B, 1'b0, 4'd7);
    step();
    n_checks++;
    if (alu_cin !== 1'b0 || alu_sel !== 4'd6)
      $display("FAIL cin_force: got cin=%b sel=%h want 0/6", alu_cin, alu_sel);
    else n_pass++;
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_f !== 32'hAAAAAAAA)
      $display("FAIL xor_rsp: got v=%b f=%h want 1/AAAAAAAA", rsp_valid, rsp_f);
    else n_pass++;
    ack();
    push(4'hC, 1'b1, A, B, 1'b0, 4'd9);
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL illegal_e0: got v=%b want 0", rsp_valid);
    else n_pass++;
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_f !== 32'h0 || rsp_zero !== 1'b1 ||
        rsp_cout !== 1'b0 || rsp_tag !== 4'd9)
      $display("FAIL illegal_rsp: got v=%b err=%b f=%h z=%b c=%b tag=%h want 1/1/0/1/0/9",
               rsp_valid, rsp_err, rsp_f, rsp_zero, rsp_cout, rsp_tag);
    else n_pass++;
    n_checks++;
    if (alu_sel !== 4'd6 || alu_a !== A || alu_cin !== 1'b0)
      $display("FAIL illegal_alu_hold: got sel=%h a=%h cin=%b want 6/%h/0", alu_sel, alu_a, alu_cin, A);
    else n_pass++;
    ack();
  endtask

  task automatic test_back_to_back();
    int got, last_c;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(4'd1, 1'b0, 32'(i), 32'h100, 1'b0, 4'(i));
      if (i == 4) begin
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL bp_ready_before5: got %b want 1", cmd_ready);
        else n_pass++;
      end
      step();
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL bp_full: got ready=%b busy=%b want 0/1", cmd_ready, busy);
    else n_pass++;
    rsp_ready = 1'b1;
    got = 0; last_c = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (rsp_valid) begin
        n_checks++;
        if (rsp_tag !== 4'(got) || rsp_f !== 32'h100 + 32'(got))
          $display("FAIL bp_rsp%0d: got tag=%h f=%h want %h/%h", got, rsp_tag, rsp_f,
                   got, 32'h100 + 32'(got));
        else n_pass++;
        if (got > 0) begin
          n_checks++;
          if (c - last_c != 2) $display("FAIL bp_gap%0d: got %0d want 2", got, c - last_c);
          else n_pass++;
        end
        last_c = c;
        got++;
      end
      step();
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (got != 5 || busy !== 1'b0) $display("FAIL bp_count: got %0d busy=%b want 5/0", got, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cmd(4'd1, 1'b0, 32'd1, 32'd2, 1'b0, 4'(10 + i));
      step();
    end
    set_cmd(4'd1, 1'b0, 32'd1, 32'd2, 1'b0, 4'd13);
    rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || alu_a !== 32'd1)
      $display("FAIL mid_wait: got v=%b busy=%b a=%h want 0/1/1", rsp_valid, busy, alu_a);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({alu_a, alu_b, alu_cin, alu_sel, rsp_valid, rsp_f, rsp_cout, rsp_zero,
         rsp_err, rsp_tag, busy} !== '0 || cmd_ready !== 1'b1)
      $display("FAIL mid_reset: got a=%h v=%b f=%h busy=%b ready=%b want 0s/ready 1",
               alu_a, rsp_valid, rsp_f, busy, cmd_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL post_reset_quiet: got %0d active cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_chain_after_reset();
    push(4'd0, 1'b1, 32'hFFFFFFFF, B, 1'b1, 4'd2);
    step(); step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_f !== 32'h00000001 || rsp_tag !== 4'd2 || rsp_zero !== 1'b0)
      $display("FAIL chain_reset: got v=%b f=%h tag=%h z=%b want 1/00000001/2/0",
               rsp_valid, rsp_f, rsp_tag, rsp_zero);
    else n_pass++;
    ack();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_chain();
    test_cin_force_illegal();
    test_back_to_back();
    test_reset_mid();
    test_chain_after_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
